// File: rtl/modmul_sched.sv
// Round-robin front end for a shared pipelined modular multiplier: arbitrates
// requesters, tags each issue with its id and returns results in issue order.
module modmul_sched #(
   parameter  int NREQ   = 4,
   parameter  int LOGQ   = 32,
   parameter  int LOGQH  = 15,
   parameter  int LOGT   = 32,
   parameter  int MM_LAT = 6,
   localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*LOGQ-1:0] req_A,
   input  logic [NREQ*LOGQ-1:0] req_B,
   output logic [NREQ-1:0]      req_ready,
   output logic [LOGQ-1:0]      mm_A,
   output logic [LOGQ-1:0]      mm_B,
   output logic [LOGQH-1:0]     mm_qH,
   input  logic [LOGT-1:0]      mm_T,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [LOGT-1:0]      rsp_T,
   input  logic                 cfg_we,
   input  logic [LOGQH-1:0]     cfg_qH,
   output logic                 cfg_err,
   output logic                 busy
);

   logic [IDW-1:0]    ptr_q, ptr_d;
   logic              iss_vld_q, iss_vld_d;
   logic [IDW-1:0]    iss_id_q, iss_id_d;
   logic [LOGQ-1:0]   mm_a_q, mm_a_d;
   logic [LOGQ-1:0]   mm_b_q, mm_b_d;
   logic [MM_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [IDW-1:0]    tag_id_q [MM_LAT];
   logic [IDW-1:0]    tag_id_d [MM_LAT];
   logic              rsp_vld_q, rsp_vld_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [LOGT-1:0]   rsp_t_q, rsp_t_d;
   logic [LOGQH-1:0]  qh_q, qh_d;
   logic              cfg_err_q, cfg_err_d;

   logic              gnt_found;
   logic [IDW-1:0]    gnt_idx;
   logic              busy_w;

   // Arbiter: first requester at or after ptr; a config write blocks all grants.
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!gnt_found && req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(j);
         end
      end
      if (rst || cfg_we) gnt_found = 1'b0;
      req_ready = '0;
      if (gnt_found) req_ready[gnt_idx] = 1'b1;
   end

   assign busy_w = iss_vld_q | (|tag_vld_q) | rsp_vld_q;

   always_comb begin
      ptr_d     = ptr_q;
      iss_vld_d = gnt_found;
      iss_id_d  = gnt_idx;
      mm_a_d    = mm_a_q;
      mm_b_d    = mm_b_q;
      if (gnt_found) begin
         ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         mm_a_d = req_A[int'(gnt_idx)*LOGQ +: LOGQ];
         mm_b_d = req_B[int'(gnt_idx)*LOGQ +: LOGQ];
      end

      // Tag pipe mirrors the multiplier so the last stage lines up with mm_T.
      tag_vld_d[0] = iss_vld_q;
      tag_id_d[0]  = iss_id_q;
      for (int k = 1; k < MM_LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_id_d[k]  = tag_id_q[k-1];
      end

      rsp_vld_d = tag_vld_q[MM_LAT-1];
      rsp_id_d  = rsp_id_q;
      rsp_t_d   = rsp_t_q;
      if (tag_vld_q[MM_LAT-1]) begin
         rsp_id_d = tag_id_q[MM_LAT-1];
         rsp_t_d  = mm_T;
      end

      qh_d      = qh_q;
      cfg_err_d = 1'b0;
      if (cfg_we) begin
         if (busy_w) cfg_err_d = 1'b1;
         else        qh_d      = cfg_qH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= '0;
         iss_vld_q <= 1'b0;
         iss_id_q  <= '0;
         mm_a_q    <= '0;
         mm_b_q    <= '0;
         tag_vld_q <= '0;
         rsp_vld_q <= 1'b0;
         rsp_id_q  <= '0;
         rsp_t_q   <= '0;
         qh_q      <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         iss_vld_q <= iss_vld_d;
         iss_id_q  <= iss_id_d;
         mm_a_q    <= mm_a_d;
         mm_b_q    <= mm_b_d;
         tag_vld_q <= tag_vld_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_id_q  <= rsp_id_d;
         rsp_t_q   <= rsp_t_d;
         qh_q      <= qh_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Tag ids are only meaningful under their valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < MM_LAT; k++) tag_id_q[k] <= tag_id_d[k];
   end

   assign mm_A      = mm_a_q;
   assign mm_B      = mm_b_q;
   assign mm_qH     = qh_q;
   assign rsp_valid = rsp_vld_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_T     = rsp_t_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = busy_w;

endmodule

// File: tb/tb_modmul_sched.sv
// Directed bench for modmul_sched with a 6-cycle A*B mod Q multiplier model.
module tb_modmul_sched;

   localparam int NREQ = 4, LOGQ = 32, LOGQH = 15, LOGT = 32, MM_LAT = 6, IDW = 2;
   localparam logic [63:0] Q = 64'hFFFF_FFFB;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*LOGQ-1:0] req_A, req_B;
   logic [NREQ-1:0]      req_ready;
   logic [LOGQ-1:0]      mm_A, mm_B;
   logic [LOGQH-1:0]     mm_qH;
   logic [LOGT-1:0]      mm_T;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [LOGT-1:0]      rsp_T;
   logic                 cfg_we;
   logic [LOGQH-1:0]     cfg_qH;
   logic                 cfg_err;
   logic                 busy;

   int nvec = 0;
   int nerr = 0;

   modmul_sched #(.NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(LOGQH), .LOGT(LOGT), .MM_LAT(MM_LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
      .req_ready(req_ready), .mm_A(mm_A), .mm_B(mm_B), .mm_qH(mm_qH), .mm_T(mm_T),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_T(rsp_T), .cfg_we(cfg_we),
      .cfg_qH(cfg_qH), .cfg_err(cfg_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Multiplier model: operands seen at cycle t produce mm_T at t+MM_LAT.
   logic [LOGT-1:0] pipe [MM_LAT];
   always @(posedge clk) begin
      pipe[0] <= LOGT'((64'(mm_A) * 64'(mm_B)) % Q);
      for (int k = 1; k < MM_LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign mm_T = pipe[MM_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL idle_timeout busy=%0b required 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'b1111; cfg_we = 1'b0; cfg_qH = '0;
      req_A = '0; req_B = '0;
      tick(); tick();
      #1;
      nvec++;
      if (req_ready !== 4'b0000) begin nerr++; $display("FAIL rst_ready got %b required 0000", req_ready); end
      nvec++;
      if ({rsp_valid, rsp_id, rsp_T, cfg_err, busy} !== '0) begin
         nerr++; $display("FAIL rst_outputs got v=%b id=%0d T=%0d err=%b busy=%b required all 0",
                          rsp_valid, rsp_id, rsp_T, cfg_err, busy);
      end
      nvec++;
      if ({mm_A, mm_B, mm_qH} !== '0) begin
         nerr++; $display("FAIL rst_data got A=%0h B=%0h qH=%0h required 0", mm_A, mm_B, mm_qH);
      end
      rst = 1'b0; req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0] exp_r;
      int got_id [8];
      int got_t  [8];
      int got_cy [8];
      int n;
      for (int i = 0; i < NREQ; i++) begin
         req_A[i*LOGQ +: LOGQ] = 32'(10 + i);
         req_B[i*LOGQ +: LOGQ] = 32'(100 + i);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_r = 4'b0001 << (k % 4);
         nvec++;
         if (req_ready !== exp_r) begin
            nerr++; $display("FAIL fair_grant%0d got %b required %b", k, req_ready, exp_r);
         end
         tick();
      end
      req_valid = 4'b0000;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid === 1'b1 && n < 8) begin
            got_id[n] = int'(rsp_id); got_t[n] = int'(rsp_T); got_cy[n] = c; n++;
         end
         tick();
      end
      nvec++;
      if (n != 8) begin nerr++; $display("FAIL fair_count got %0d required 8", n); end
      for (int k = 0; k < n; k++) begin
         nvec++;
         if (got_id[k] != k % 4 || got_cy[k] != k ||
             got_t[k] != (10 + k % 4) * (100 + k % 4)) begin
            nerr++;
            $display("FAIL fair_rsp%0d got id=%0d T=%0d cyc=%0d required id=%0d T=%0d cyc=%0d",
                     k, got_id[k], got_t[k], got_cy[k], k % 4, (10 + k % 4) * (100 + k % 4), k);
         end
      end
   endtask

   task automatic test_single();
      wait_idle();
      req_A[2*LOGQ +: LOGQ] = 32'd3;
      req_B[2*LOGQ +: LOGQ] = 32'd5;
      req_valid = 4'b0100;
      #1;
      nvec++;
      if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready got %b required 0100", req_ready); end
      tick();
      req_valid = 4'b0000;
      nvec++;
      if (mm_A !== 32'd3 || mm_B !== 32'd5) begin
         nerr++; $display("FAIL single_issue got A=%0d B=%0d required 3 5", mm_A, mm_B);
      end
      for (int c = 1; c < 7; c++) tick();
      nvec++;
      if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL single_early got rsp_valid=%b required 0", rsp_valid); end
      tick();
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_T !== 32'd15) begin
         nerr++; $display("FAIL single_rsp got v=%b id=%0d T=%0d required 1 2 15", rsp_valid, rsp_id, rsp_T);
      end
      nvec++;
      if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy_rsp got %b required 1", busy); end
      tick();
      nvec++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         nerr++; $display("FAIL single_done got busy=%b v=%b required 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_config();
      wait_idle();
      cfg_we = 1'b1; cfg_qH = 15'h1234; req_valid = 4'b1111;
      #1;
      nvec++;
      if (req_ready !== 4'b0000) begin nerr++; $display("FAIL cfg_block got %b required 0000", req_ready); end
      tick();
      cfg_we = 1'b0; req_valid = 4'b0000;
      nvec++;
      if (mm_qH !== 15'h1234 || cfg_err !== 1'b0) begin
         nerr++; $display("FAIL cfg_idle got qH=%0h err=%b required 1234 0", mm_qH, cfg_err);
      end
      // ptr is 3 after the single test; requester 1 is granted, ptr becomes 2
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0000;
      cfg_we = 1'b1; cfg_qH = 15'h5678;
      tick();
      cfg_we = 1'b0;
      nvec++;
      if (cfg_err !== 1'b1 || mm_qH !== 15'h1234) begin
         nerr++; $display("FAIL cfg_busy got err=%b qH=%0h required 1 1234", cfg_err, mm_qH);
      end
      tick();
      nvec++;
      if (cfg_err !== 1'b0) begin nerr++; $display("FAIL cfg_err_pulse got %b required 0", cfg_err); end
   endtask

   task automatic test_reset_midflight();
      int pulses;
      wait_idle();
      req_valid = 4'b0111;
      tick(); tick(); tick();
      req_valid = 4'b0000;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid === 1'b1) pulses++;
         tick();
      end
      nvec++;
      if (pulses != 0) begin nerr++; $display("FAIL flush_rsp got %0d pulses required 0", pulses); end
      req_valid = 4'b1001;
      #1;
      nvec++;
      if (req_ready !== 4'b0001) begin nerr++; $display("FAIL flush_ptr got %b required 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
   endtask

   task automatic test_wrap();
      wait_idle();
      // ptr is 1; a grant to requester 2 moves it to 3
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1001;
      #1;
      nvec++;
      if (req_ready !== 4'b1000) begin nerr++; $display("FAIL wrap_g3 got %b required 1000", req_ready); end
      tick();
      nvec++;
      if (req_ready !== 4'b0001) begin nerr++; $display("FAIL wrap_g0 got %b required 0001", req_ready); end
      tick();
      req_valid = 4'b0001;
      #1;
      nvec++;
      if (req_ready !== 4'b0001) begin nerr++; $display("FAIL sparse_g0 got %b required 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single();
      test_config();
      test_reset_midflight();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no completion required finish");
      $fatal(1);
   end

endmodule
